dac_sample_sequencer: RTL and testbench

- Sits directly upstream of the DAC SPI serialiser; consumes stereo sample pairs from the synthesis core and emits two 24-bit DAC command words per pair (channel A, then channel B with simultaneous load).
- Drives the serialiser's i_data/i_send inputs and obeys its o_Ready handshake.
- Holds one pending pair, so a new sample can arrive while the previous pair is still shifting out.
- Flags overruns.

---
 rtl/dac_seq_pkg.sv | 36 +++
 rtl/dac_sample_sequencer.sv | 122 ++++++++++++
 tb/tb_dac_sample_sequencer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dac_seq_pkg.sv
// Shared types and helpers for the DAC sample sequencer.
// Provides the FSM state enum, default command bytes, the midscale code and
// the command-word builder used for both channel words.
package dac_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACK_A  = 2'd1,
    WAIT_B = 2'd2,
    ACK_B  = 2'd3
  } seq_state_t;

  localparam logic [7:0]  DEF_CMD_A   = 8'h10;   // write buffer A
  localparam logic [7:0]  DEF_CMD_B   = 8'h34;   // write buffer B, load both
  localparam logic [15:0] MIDSCALE_OB = 16'h8000;

  // Build one 24-bit DAC command: control byte followed by the 16-bit code.
  // Muted output is midscale, which is 0x8000 in offset binary and 0 in
  // two's complement.
  function automatic logic [23:0] make_word(
    input logic [7:0]  cmd,
    input logic [15:0] sample,
    input logic        mute,
    input logic        offset_binary
  );
    logic [15:0] code;
    if (mute)
      code = offset_binary ? MIDSCALE_OB : 16'h0000;
    else if (offset_binary)
      code = {~sample[15], sample[14:0]};
    else
      code = sample;
    return {cmd, code};
  endfunction

endpackage

// File: rtl/dac_sample_sequencer.sv
// Purpose: turns stereo sample pairs into two DAC command words (A, then B).
// Latency: word A o_send one edge after pending loads (serialiser idle/ready).
// Backpressure: waits on i_ready; one pending pair, overwrite flags o_overrun.
// Ports:
//   i_clock, i_reset_n                 clock, async active-low reset
//   i_sample_valid, i_sample_l/r       one-cycle sample pair strobe + data
//   i_mute, i_clear_overrun            midscale force, sticky-flag clear
//   i_ready                            serialiser ready handshake
//   o_data, o_send                     command word and its one-cycle strobe
//   o_busy, o_overrun                  activity flag, sticky overwrite flag
module dac_sample_sequencer
  import dac_seq_pkg::*;
#(
  parameter logic [7:0] CMD_A         = DEF_CMD_A,
  parameter logic [7:0] CMD_B         = DEF_CMD_B,
  parameter bit         OFFSET_BINARY = 1'b1
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_sample_valid,
  input  logic [15:0] i_sample_l,
  input  logic [15:0] i_sample_r,
  input  logic        i_mute,
  input  logic        i_clear_overrun,
  input  logic        i_ready,
  output logic [23:0] o_data,
  output logic        o_send,
  output logic        o_busy,
  output logic        o_overrun
);

  seq_state_t  state;
  logic [15:0] pend_l;
  logic [15:0] pend_r;
  logic        pend_full;
  logic [15:0] work_r;
  logic        mute_q;

  logic        consume;
  logic        pend_full_nxt;
  logic        active_nxt;

  // The pending pair is handed to the FSM only from IDLE with Ready high.
  assign consume = (state == IDLE) && pend_full && i_ready;

  // A strobe always refills pending, even on the consume edge.
  assign pend_full_nxt = i_sample_valid ? 1'b1 : (pend_full && !consume);

  // Whether the FSM is outside IDLE after this edge; lets o_busy be
  // registered yet line up with the state it describes.
  always_comb begin
    active_nxt = 1'b1;
    case (state)
      IDLE:    active_nxt = consume;
      ACK_B:   active_nxt = i_ready;
      default: active_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pend_l    <= 16'h0000;
      pend_r    <= 16'h0000;
      pend_full <= 1'b0;
      o_overrun <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      pend_full <= pend_full_nxt;
      o_busy    <= pend_full_nxt || active_nxt;
      if (i_sample_valid) begin
        pend_l <= i_sample_l;
        pend_r <= i_sample_r;
      end
      // A new overwrite beats a same-cycle clear.
      if (i_sample_valid && pend_full && !consume)
        o_overrun <= 1'b1;
      else if (i_clear_overrun)
        o_overrun <= 1'b0;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state  <= IDLE;
      o_data <= 24'h000000;
      o_send <= 1'b0;
      work_r <= 16'h0000;
      mute_q <= 1'b0;
    end else begin
      o_send <= 1'b0;
      case (state)
        IDLE: begin
          if (consume) begin
            work_r <= pend_r;
            mute_q <= i_mute;
            o_data <= make_word(CMD_A, pend_l, i_mute, OFFSET_BINARY);
            o_send <= 1'b1;
            state  <= ACK_A;
          end
        end
        // Ready is still high for a cycle after send; only its fall counts.
        ACK_A: begin
          if (!i_ready)
            state <= WAIT_B;
        end
        WAIT_B: begin
          if (i_ready) begin
            o_data <= make_word(CMD_B, work_r, mute_q, OFFSET_BINARY);
            o_send <= 1'b1;
            state  <= ACK_B;
          end
        end
        ACK_B: begin
          if (!i_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_sample_sequencer.sv
// Bench for dac_sample_sequencer: emulated serialiser, word-queue model,
// per-cycle compare plus literal expectations on the sent word log.
module tb_dac_sample_sequencer;

  logic        i_clock = 1'b0;
  logic        i_reset_n;
  logic        i_sample_valid;
  logic [15:0] i_sample_l;
  logic [15:0] i_sample_r;
  logic        i_mute;
  logic        i_clear_overrun;
  logic        i_ready;
  logic [23:0] o_data;
  logic        o_send;
  logic        o_busy;
  logic        o_overrun;

  int checks   = 0;
  int failures = 0;

  dac_sample_sequencer dut (
    .i_clock        (i_clock),
    .i_reset_n      (i_reset_n),
    .i_sample_valid (i_sample_valid),
    .i_sample_l     (i_sample_l),
    .i_sample_r     (i_sample_r),
    .i_mute         (i_mute),
    .i_clear_overrun(i_clear_overrun),
    .i_ready        (i_ready),
    .o_data         (o_data),
    .o_send         (o_send),
    .o_busy         (o_busy),
    .o_overrun      (o_overrun)
  );

  always #5 i_clock = ~i_clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- serialiser emulation ----------------
  int ser_phase    = 0;
  int ser_cnt      = 0;
  int ser_drop_dly = 0;   // extra cycles Ready stays high after send
  int ser_busy_len = 3;   // cycles Ready stays low while shifting

  always @(negedge i_clock) begin
    if (!i_reset_n) begin
      i_ready   = 1'b1;
      ser_phase = 0;
    end else if (ser_phase == 1) begin
      if (ser_cnt == 0) begin i_ready = 1'b0; ser_cnt = ser_busy_len; ser_phase = 2; end
      else ser_cnt--;
    end else if (ser_phase == 2) begin
      if (ser_cnt == 0) begin i_ready = 1'b1; ser_phase = 0; end
      else ser_cnt--;
    end else if (o_send) begin
      ser_cnt   = ser_drop_dly;
      ser_phase = 1;
    end
  end

  // ---------------- behavioural model ----------------
  // The sequencer is a queue of words awaiting a free serialiser. A word may
  // go out when Ready is high and the previous word's Ready drop was seen.
  // A new pair becomes words only when no word of the previous pair remains.
  logic [15:0] mp_l, mp_r;
  bit          mp_full;
  bit          m_wait_drop;
  logic [23:0] m_words[$];
  logic [23:0] m_data;
  bit          m_send, m_busy, m_ovr;
  bit          m_take, m_launch;

  function automatic logic [23:0] exp_word(input logic [7:0] cmd, input logic [15:0] s, input bit mute);
    logic [15:0] code;
    code = mute ? 16'h8000 : (s + 16'h8000);   // offset binary = value + half range
    return {cmd, code};
  endfunction

  always @(posedge i_clock) begin
    if (!i_reset_n) begin
      mp_full = 0; m_wait_drop = 0; m_words.delete();
      m_data = 24'h0; m_send = 0; m_busy = 0; m_ovr = 0;
      mp_l = 16'h0; mp_r = 16'h0;
    end else begin
      m_take = 0; m_launch = 0;
      if (!m_wait_drop && i_ready) begin
        if (m_words.size() > 0) begin
          m_data = m_words.pop_front();
          m_launch = 1;
        end else if (mp_full) begin
          m_data = exp_word(8'h10, mp_l, i_mute);
          m_words.push_back(exp_word(8'h34, mp_r, i_mute));
          m_take = 1; m_launch = 1;
        end
      end else if (m_wait_drop && !i_ready) begin
        m_wait_drop = 0;
      end
      if (m_launch) m_wait_drop = 1;
      m_send = m_launch;
      if (i_sample_valid && mp_full && !m_take) m_ovr = 1;
      else if (i_clear_overrun) m_ovr = 0;
      if (i_sample_valid) begin
        mp_l = i_sample_l; mp_r = i_sample_r; mp_full = 1;
      end else if (m_take) begin
        mp_full = 0;
      end
      m_busy = m_wait_drop || (m_words.size() > 0) || mp_full;
    end
  end

  // ---------------- per-cycle compare + sent-word log ----------------
  logic [23:0] sent_log[$];

  always @(negedge i_clock) begin
    if (i_reset_n) begin
      chk("cyc_send", {31'd0, o_send}, {31'd0, m_send});
      chk("cyc_data", {8'd0, o_data}, {8'd0, m_data});
      chk("cyc_busy", {31'd0, o_busy}, {31'd0, m_busy});
      chk("cyc_overrun", {31'd0, o_overrun}, {31'd0, m_ovr});
      if (o_send) sent_log.push_back(o_data);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge i_clock);
    #1;
  endtask

  task automatic strobe(input logic [15:0] l, input logic [15:0] r);
    i_sample_l = l; i_sample_r = r; i_sample_valid = 1'b1;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((o_busy || !i_ready) && n < 300) begin tick(); n++; end
    chk(nm, {31'd0, (n < 300)}, 32'd1);
  endtask

  task automatic chk_log(input string nm, input int idx, input logic [23:0] exp);
    if (sent_log.size() > idx) chk(nm, {8'd0, sent_log[idx]}, {8'd0, exp});
    else chk({nm, "_missing"}, sent_log.size(), idx + 1);
  endtask

  int base;

  initial begin
    i_reset_n = 1'b0; i_sample_valid = 1'b0; i_sample_l = 16'h0; i_sample_r = 16'h0;
    i_mute = 1'b0; i_clear_overrun = 1'b0; i_ready = 1'b1;
    #3;
    chk("rst_data", {8'd0, o_data}, 32'd0);
    chk("rst_send", {31'd0, o_send}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_overrun", {31'd0, o_overrun}, 32'd0);
    tick(); tick();
    i_reset_n = 1'b1;
    tick(); tick();

    // Basic pair, latency and word B after Ready returns.
    base = sent_log.size();
    strobe(16'h0000, 16'h7FFF);
    tick(); i_sample_valid = 1'b0;
    chk("lat_no_early_send", {31'd0, o_send}, 32'd0);
    chk("lat_busy_pending", {31'd0, o_busy}, 32'd1);
    tick();
    chk("lat_send_a", {31'd0, o_send}, 32'd1);
    chk("lat_data_a", {8'd0, o_data}, 32'h00108000);
    tick();
    chk("send_a_one_cycle", {31'd0, o_send}, 32'd0);
    wait_idle("basic_idle");
    chk("basic_count", sent_log.size() - base, 32'd2);
    chk_log("basic_b", base + 1, 24'h34FFFF);
    chk("basic_data_hold", {8'd0, o_data}, 32'h0034FFFF);

    // Mute latched at launch; toggling it mid-pair does not affect word B.
    base = sent_log.size();
    i_mute = 1'b1;
    strobe(16'h0000, 16'h7FFF);
    tick(); i_sample_valid = 1'b0;
    tick(); i_mute = 1'b0;
    chk("mute_a", {8'd0, o_data}, 32'h00108000);
    tick(); i_mute = 1'b1;
    tick(); i_mute = 1'b0;
    wait_idle("mute_idle");
    chk_log("mute_b", base + 1, 24'h348000);

    // Overrun: P2 overwritten by P3 while P1 shifts.
    base = sent_log.size();
    ser_busy_len = 4;
    strobe(16'h1234, 16'h8000);
    tick(); i_sample_valid = 1'b0;
    tick(); strobe(16'h1111, 16'h2222);
    tick(); strobe(16'hFFFF, 16'h0001);
    tick(); i_sample_valid = 1'b0;
    chk("ovr_set", {31'd0, o_overrun}, 32'd1);
    wait_idle("ovr_idle");
    chk("ovr_count", sent_log.size() - base, 32'd4);
    chk_log("ovr_p1a", base + 0, 24'h109234);
    chk_log("ovr_p1b", base + 1, 24'h340000);
    chk_log("ovr_p3a", base + 2, 24'h107FFF);
    chk_log("ovr_p3b", base + 3, 24'h348001);
    chk("ovr_sticky", {31'd0, o_overrun}, 32'd1);
    i_clear_overrun = 1'b1;
    tick(); i_clear_overrun = 1'b0;
    chk("ovr_cleared", {31'd0, o_overrun}, 32'd0);

    // Strobe on the exact launch edge: no overrun, both pairs sent in order.
    base = sent_log.size();
    ser_busy_len = 3;
    strobe(16'h4000, 16'hC000);
    tick(); strobe(16'h8001, 16'h0002);
    tick(); i_sample_valid = 1'b0;
    chk("launch_no_ovr", {31'd0, o_overrun}, 32'd0);
    wait_idle("launch_idle");
    chk("launch_count", sent_log.size() - base, 32'd4);
    chk_log("launch_q1a", base + 0, 24'h10C000);
    chk_log("launch_q1b", base + 1, 24'h344000);
    chk_log("launch_q2a", base + 2, 24'h100001);
    chk_log("launch_q2b", base + 3, 24'h348002);
    chk("launch_no_ovr_end", {31'd0, o_overrun}, 32'd0);

    // Slow Ready drop: Ready stays high several cycles after word A.
    base = sent_log.size();
    ser_drop_dly = 3;
    strobe(16'h0100, 16'hFF00);
    tick(); i_sample_valid = 1'b0;
    wait_idle("slow_idle");
    chk("slow_count", sent_log.size() - base, 32'd2);
    chk_log("slow_a", base + 0, 24'h108100);
    chk_log("slow_b", base + 1, 24'h347F00);
    ser_drop_dly = 0;

    // Async reset while waiting for Ready before word B.
    base = sent_log.size();
    ser_busy_len = 8;
    strobe(16'h2000, 16'h3000);
    tick(); i_sample_valid = 1'b0;
    tick(); tick(); tick(); tick();
    chk("rst_mid_ready_low", {31'd0, i_ready}, 32'd0);
    i_reset_n = 1'b0;
    #1;
    chk("rst_mid_data", {8'd0, o_data}, 32'd0);
    chk("rst_mid_send", {31'd0, o_send}, 32'd0);
    chk("rst_mid_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_mid_overrun", {31'd0, o_overrun}, 32'd0);
    tick(); tick();
    i_reset_n = 1'b1;
    ser_busy_len = 3;
    repeat (20) tick();
    chk("rst_no_word_b", sent_log.size() - base, 32'd1);
    chk("rst_idle_busy", {31'd0, o_busy}, 32'd0);

    // Fresh pair after reset still works.
    base = sent_log.size();
    strobe(16'h7FFF, 16'h8000);
    tick(); i_sample_valid = 1'b0;
    wait_idle("post_rst_idle");
    chk_log("post_rst_a", base + 0, 24'h10FFFF);
    chk_log("post_rst_b", base + 1, 24'h340000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
